// File: rtl/rpn_stack_controller.sv
// rpn_stack_controller: register stack of DEPTH operands for reverse-Polish
// entry. It takes push, binary-operation and undo commands. Every accepted
// command occupies one action cycle and then returns to IDLE. One level of
// operation undo is kept in a pair of saved-operand registers.
module rpn_stack_controller #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enter_pulse,
  input  logic             i_op_pulse,
  input  logic             i_undo,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic [1:0]       i_op_code,
  output logic [WIDTH-1:0] o_top,
  output logic [DW-1:0]    o_depth,
  output logic [3:0]       o_flags,
  output logic [1:0]       o_err_code,
  output logic             o_busy,
  output logic [2:0]       o_status
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_PUSH    = 3'b001,
    S_POP     = 3'b010,
    S_EXEC    = 3'b011,
    S_RESTORE = 3'b100,
    S_ERROR   = 3'b111
  } state_t;

  typedef enum logic [1:0] {
    LA_NONE = 2'd0,
    LA_PUSH = 2'd1,
    LA_EXEC = 2'd2
  } last_t;

  state_t           r_state;
  last_t            r_last;
  logic [DW-1:0]    r_depth;
  logic [3:0]       r_flags;
  logic [1:0]       r_err;
  logic [WIDTH-1:0] r_saved_a;
  logic [WIDTH-1:0] r_saved_b;
  logic [WIDTH-1:0] r_stack [DEPTH];

  // Slot indices relative to the current depth. They are only used when the
  // command decode has confirmed that the slot is valid.
  logic [IW-1:0]    w_top_idx;
  logic [IW-1:0]    w_sec_idx;
  logic [IW-1:0]    w_push_idx;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  assign w_top_idx  = IW'(r_depth - DW'(1));
  assign w_sec_idx  = IW'(r_depth - DW'(2));
  assign w_push_idx = IW'(r_depth);
  assign w_a        = r_stack[w_sec_idx];
  assign w_b        = r_stack[w_top_idx];

  // Command decode. Enter has the highest priority, then Op, then Undo.
  // Pulses are honoured only in IDLE.
  logic w_idle, w_cmd_enter, w_cmd_op, w_cmd_undo;
  logic w_do_push, w_do_exec, w_do_restore, w_do_pop;
  logic w_err_ovf, w_err_und, w_err_empty;
  assign w_idle       = (r_state == S_IDLE);
  assign w_cmd_enter  = w_idle & i_enter_pulse;
  assign w_cmd_op     = w_idle & ~i_enter_pulse & i_op_pulse;
  assign w_cmd_undo   = w_idle & ~i_enter_pulse & ~i_op_pulse & i_undo;
  assign w_err_ovf    = w_cmd_enter & (r_depth == DW'(DEPTH));
  assign w_do_push    = w_cmd_enter & (r_depth != DW'(DEPTH));
  assign w_err_und    = w_cmd_op & (r_depth < DW'(2));
  assign w_do_exec    = w_cmd_op & (r_depth >= DW'(2));
  assign w_do_restore = w_cmd_undo & (r_last == LA_EXEC);
  assign w_err_empty  = w_cmd_undo & (r_last != LA_EXEC) & (r_depth == '0);
  assign w_do_pop     = w_cmd_undo & (r_last != LA_EXEC) & (r_depth != '0);

  // ALU on the top two entries; flags packed as {N,Z,C,V}.
  logic [WIDTH-1:0] w_result;
  logic [WIDTH:0]   w_ext;
  logic             w_c, w_v;
  always_comb begin
    w_ext    = '0;
    w_result = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    case (i_op_code)
      2'b00: begin
        w_ext    = {1'b0, w_a} + {1'b0, w_b};
        w_result = w_ext[WIDTH-1:0];
        w_c      = w_ext[WIDTH];
        w_v      = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_result[WIDTH-1] != w_a[WIDTH-1]);
      end
      2'b01: begin
        w_ext    = {1'b0, w_a} - {1'b0, w_b};
        w_result = w_ext[WIDTH-1:0];
        // The top bit of the extended difference is the borrow, so the
        // carry flag is its complement (set when A >= B unsigned).
        w_c      = ~w_ext[WIDTH];
        w_v      = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_result[WIDTH-1] != w_a[WIDTH-1]);
      end
      2'b10:   w_result = w_a & w_b;
      default: w_result = w_a | w_b;
    endcase
  end

  // Each stack entry is written directly from the command decode. Entries
  // have no reset because slots above the depth are never observed.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Write the entry selected by a push, an operation result or an undo restore.
      always_ff @(posedge i_clk) begin
        if (w_do_push && (w_push_idx == IW'(gi)))
          r_stack[gi] <= i_data_in;
        else if (w_do_exec && (w_sec_idx == IW'(gi)))
          r_stack[gi] <= w_result;
        else if (w_do_restore && (w_top_idx == IW'(gi)))
          r_stack[gi] <= r_saved_a;
        else if (w_do_restore && (w_push_idx == IW'(gi)))
          r_stack[gi] <= r_saved_b;
      end
    end
  endgenerate

  // Control FSM. Depth, flags, error code and undo state update on the
  // accepting edge. Each action state lasts exactly one cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_last    <= LA_NONE;
      r_depth   <= '0;
      r_flags   <= '0;
      r_err     <= 2'b00;
      r_saved_a <= '0;
      r_saved_b <= '0;
    end else if (!w_idle) begin
      r_state <= S_IDLE;
    end else if (w_err_ovf || w_err_und || w_err_empty) begin
      r_state <= S_ERROR;
      r_err   <= w_err_ovf ? 2'b01 : (w_err_und ? 2'b10 : 2'b11);
    end else if (w_do_push) begin
      r_state <= S_PUSH;
      r_err   <= 2'b00;
      r_depth <= r_depth + DW'(1);
      r_last  <= LA_PUSH;
    end else if (w_do_exec) begin
      r_state   <= S_EXEC;
      r_err     <= 2'b00;
      r_depth   <= r_depth - DW'(1);
      r_last    <= LA_EXEC;
      r_saved_a <= w_a;
      r_saved_b <= w_b;
      r_flags   <= {w_result[WIDTH-1], (w_result == '0), w_c, w_v};
    end else if (w_do_restore) begin
      r_state <= S_RESTORE;
      r_err   <= 2'b00;
      r_depth <= r_depth + DW'(1);
      r_last  <= LA_NONE;
    end else if (w_do_pop) begin
      r_state <= S_POP;
      r_err   <= 2'b00;
      r_depth <= r_depth - DW'(1);
      r_last  <= LA_NONE;
    end
  end

  assign o_top      = (r_depth != '0) ? r_stack[w_top_idx] : '0;
  assign o_depth    = r_depth;
  assign o_flags    = r_flags;
  assign o_err_code = r_err;
  assign o_busy     = (r_state != S_IDLE);
  assign o_status   = r_state;

endmodule

// File: doc/rpn_stack_controller.md
# rpn_stack_controller

Parametrised successor of the fixed three-step reverse-Polish entry FSM: instead of a hard-wired operand A / operand B / opcode sequence, it holds a register stack of DEPTH operands of WIDTH bits. It executes binary operations on the top two entries and supports undo of the last push or the last operation. It sits between the debounced push-button pulse generators and the seven-segment display driver, and replaces the separate operand/opcode registers and the ALU select path.

## Interface
- WIDTH, 16, operand/result width in bits (≥4)
- DEPTH, 4, stack entries (≥2)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- EnterPulse  in  1  one-cycle pulse: push DataIn
- OpPulse  in  1  one-cycle pulse: execute OpCode on top two entries
- Undo  in  1  one-cycle pulse: undo last action
- DataIn  in  WIDTH  operand to push
- OpCode  in  2  00 add, 01 sub, 10 and, 11 or
- Top  out  WIDTH  stack top entry; 0 when empty (to display)
- Depth  out  $clog2(DEPTH+1)  number of valid entries
- Flags  out  4  {N,Z,C,V} of last executed operation
- ErrCode  out  2  00 none, 01 overflow, 10 underflow, 11 undo on empty
- Busy  out  1  high whenever FSM not in IDLE
- Status  out  3  state code for debug LEDs

## Operation
- States (Status code): IDLE 000, PUSH 001, POP 010, EXEC 011, RESTORE 100, ERROR 111.
- IDLE: command priority Enter > Op > Undo when several pulses coincide; lower-priority pulses in the same cycle are dropped.
- Enter: Depth==DEPTH → ERROR, ErrCode=01. Otherwise → PUSH: entry[Depth]=DataIn, Depth+1, LastAct=PUSH.
- Op: Depth<2 → ERROR, ErrCode=10. Otherwise → EXEC.
  - Let A=entry[Depth-2], B=Top.
  - Save A,B into undo registers.
  - entry[Depth-2]=A op B (sub is A−B), Depth−1, update Flags, LastAct=EXEC.
- Undo:
  - LastAct==EXEC → RESTORE: entry[Depth-1]=savedA, entry[Depth]=savedB, Depth+1, LastAct=NONE. Flags unchanged.
  - Else Depth==0 → ERROR, ErrCode=11.
  - Else → POP: Depth−1, LastAct=NONE.
  - Only one level of operation undo; further undos pop.
- PUSH/POP/EXEC/RESTORE/ERROR each last exactly one cycle, then return to IDLE.
- ErrCode is sticky. It is cleared to 00 by the next command that does not error, on the transition out of IDLE. A failing command leaves stack, Depth, Flags and LastAct unchanged.
- Arithmetic is modulo 2^WIDTH.
  - add: C=carry out; V=signed overflow.
  - sub: C=1 when A≥B unsigned (no borrow); V=signed overflow.
  - and/or: C=0, V=0.
  - N=result MSB; Z=(result==0).
- Top is combinational from entry[Depth-1] when Depth>0, else 0.
- Entries above Depth are don't-care and are never observable.

## Timing
- Reset (asynchronous, immediate, also mid-command): state=IDLE, Depth=0, Top=0, Flags=0000, ErrCode=00, Busy=0, Status=000, LastAct=NONE, undo registers=0.
- Command pulse sampled in IDLE at edge k. At edge k the FSM enters the action state and the stack/Depth/Flags/ErrCode update at that same edge.
- Busy=1 during cycle k..k+1. The FSM is back in IDLE after edge k+1.
- Accepted-command latency: 1 cycle to result. Throughput: one command per 2 cycles.
- Pulses arriving while Busy=1 are ignored, not queued.
- Status/Busy are Moore outputs. Top/Depth/Flags/ErrCode are registered or derived from registers only; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, DEPTH=4. Push 0x05, push 0x03, Op sub → Top=0x02, Depth=1, Flags=0010 (C=1), ErrCode=00.
- Continuing: Undo → Depth=2, Top=0x03, entry[0]=0x05. Undo → Depth=1, Top=0x05. Undo → Depth=0, Top=0. Undo → ErrCode=11, Depth=0.
- Push 0x11,0x22,0x33,0x44,0x55 → fifth gives ErrCode=01, Depth=4, Top=0x44. Next push after two Undo pops → ErrCode=00.
- Depth=1, OpPulse → ErrCode=10, Depth=1, Top unchanged.
- Flags:
  - 0x7F add 0x01 → Top=0x80, NZCV=1001.
  - 0xFF add 0x01 → Top=0x00, NZCV=0110.
  - 0x0F and 0xF0 → 0x00, NZCV=0100.
- EnterPulse+Undo in the same IDLE cycle → push only.
- OpPulse one cycle after an accepted Enter (Busy=1) → ignored.
- reset asserted mid-EXEC, asynchronous to clk → all outputs reset values before the next edge.
